// File: rtl/key_debounce_pkg.sv
// Shared constants, direction encodings and helpers for the key debouncer
// and the snake control logic that consumes its direction output.
package key_debounce_pkg;

    localparam int DEF_N_KEYS     = 4;
    localparam int DEF_STABLE_CNT = 5;
    localparam int DEF_CNT_W      = 3;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Lowest set bit index of a vector, truncated to a direction code; 0 wins ties.
    function automatic logic [1:0] first_set(input logic [31:0] vec);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 31; i >= 0; i--) begin
            idx = vec[i] ? 2'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key/slow-clock inputs and debounced outputs between the key source and the
// debouncer; the debouncer sits on the slave modport.
interface key_debounce_if
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS = DEF_N_KEYS
);
    logic              clk_2ms;
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_pulse;
    logic [1:0]        dir_code;
    logic              dir_valid;

    modport master (
        output clk_2ms,
        output key_in,
        input  key_state,
        input  key_pulse,
        input  dir_code,
        input  dir_valid
    );

    modport slave (
        input  clk_2ms,
        input  key_in,
        output key_state,
        output key_pulse,
        output dir_code,
        output dir_valid
    );
endinterface

// File: rtl/key_debounce_key_filter.sv
// Single-key debounce: 2-FF synchronizer, consecutive-difference counter,
// accepted level and registered press pulse.
module key_filter
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_key_raw,
    output logic o_state,
    output logic o_pulse
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_state;
    logic             r_pulse;

    logic             w_key_sync;
    logic             w_differs;
    logic             w_accept;

    assign w_key_sync = r_sync[1];
    assign w_differs  = w_key_sync ^ r_state;
    // The increment that would reach STABLE_CNT flips the level instead.
    assign w_accept   = i_tick & w_differs & (r_cnt == LAST_CNT);

    // Bring the raw key level into the clk domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_key_raw};
        end
    end

    // Count differing samples on ticks, accept the new level, flag presses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_accept & ~r_state;
            if (!i_tick) begin
                r_cnt   <= r_cnt;
                r_state <= r_state;
            end else if (!w_differs) begin
                r_cnt   <= {CNT_W{1'b0}};
                r_state <= r_state;
            end else if (w_accept) begin
                r_cnt   <= {CNT_W{1'b0}};
                r_state <= ~r_state;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_state <= r_state;
            end
        end
    end

    assign o_state = r_state;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/key_debounce.sv
// Key debouncer top: slow-clock tick generation, per-key filters and the
// last-pressed direction register.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS     = DEF_N_KEYS,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    key_debounce_if.slave  bus
);

    logic [1:0]        r_clk_sync;
    logic              r_clk_prev;
    logic              r_armed;
    logic              r_tick;
    dir_e              r_dir_code;
    logic              r_dir_valid;

    logic              w_clk_rise;
    logic [N_KEYS-1:0] w_state;
    logic [N_KEYS-1:0] w_pulse;

    assign w_clk_rise = r_clk_sync[1] & ~r_clk_prev;

    // Synchronize the slow clock and emit one tick per rising edge; the first
    // edge after reset only arms the detector so a level already high at
    // release cannot masquerade as an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync <= 2'b00;
            r_clk_prev <= 1'b0;
            r_armed    <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], bus.clk_2ms};
            r_clk_prev <= r_clk_sync[1];
            r_armed    <= r_armed | w_clk_rise;
            r_tick     <= w_clk_rise & r_armed;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_filter #(
            .STABLE_CNT (STABLE_CNT),
            .CNT_W      (CNT_W)
        ) u_filter (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_tick    (r_tick),
            .i_key_raw (bus.key_in[g]),
            .o_state   (w_state[g]),
            .o_pulse   (w_pulse[g])
        );
    end

    // Remember the most recent press; lowest index wins simultaneous presses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dir_code  <= DIR_UP;
            r_dir_valid <= 1'b0;
        end else if (|w_pulse) begin
            r_dir_code  <= dir_e'(first_set(32'(w_pulse)));
            r_dir_valid <= 1'b1;
        end else begin
            r_dir_code  <= r_dir_code;
            r_dir_valid <= r_dir_valid;
        end
    end

    assign bus.key_state = w_state;
    assign bus.key_pulse = w_pulse;
    assign bus.dir_code  = r_dir_code;
    assign bus.dir_valid = r_dir_valid;

endmodule
